// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load clamp helper.
// No logic of its own; imported by the counter and its digit slices.
// Not applicable (no handshake).
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Non-decimal nibbles (A..F) are forced to 9 so the count is always valid BCD.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: load, up/down step on enable, terminal flags.
// Latency: digit updates on the edge where load/en is sampled.
// No backpressure; en is a pure step strobe from the ripple logic above.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       dn,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_zero
);

  bcd_digit_t digit_next;

  // Next value of this decade: load wins over stepping; steps wrap within 0..9.
  always_comb begin
    digit_next = digit;
    if (load) begin
      digit_next = bcd_clamp(ld_val);
    end else if (en) begin
      if (dn) begin
        digit_next = (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
      end else begin
        digit_next = (digit == BCD_MAX) ? BCD_ZERO : digit + 4'd1;
      end
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      digit <= BCD_ZERO;
    end else begin
      digit <= digit_next;
    end
  end

  assign at_max  = (digit == BCD_MAX);
  assign at_zero = (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit cascaded up/down BCD counter with parallel load, wrap/saturate and sticky overflow.
// Latency: count and overflow update on the edge where inc/load is sampled; flags are combinational.
// No backpressure; one step per clock while inc is high.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  input  logic                dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                clear_ovf,
  output logic [4*DIGITS-1:0] count,
  output logic                count_eq_9,
  output logic                count_eq_0,
  output logic                carry_out,
  output logic                overflow
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] en;
  logic              hold;

  assign count_eq_9 = &at_max;
  assign count_eq_0 = &at_zero;
  assign carry_out  = inc & ~load & (dn ? count_eq_0 : count_eq_9);

  // In saturate mode a terminal step freezes every digit instead of wrapping.
  assign hold = SATURATE & carry_out;

  // Ripple enable: a digit steps when every lower digit sits at the direction's terminal value.
  always_comb begin : ripple
    logic all_max;
    logic all_zero;
    all_max  = 1'b1;
    all_zero = 1'b1;
    en       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      en[i]    = inc & ~hold & (dn ? all_zero : all_max);
      all_max  = all_max & at_max[i];
      all_zero = all_zero & at_zero[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock   (clock),
      .reset   (reset),
      .en      (en[g]),
      .dn      (dn),
      .load    (load),
      .ld_val  (load_val[4*g +: 4]),
      .digit   (count[4*g +: 4]),
      .at_max  (at_max[g]),
      .at_zero (at_zero[g])
    );
  end

  // Sticky overflow: a terminal step sets it and beats a same-edge clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (carry_out) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
